// File: rtl/ac97_dmar_fetch.sv
// AC'97 downstream DMA fetch: Wishbone word reads into a prefetch FIFO, one sample pair per frame.
// Optional define AC97_DMAR_UNDERRUN_CNT_EN enables the saturating underrun counter.
module ac97_dmar_fetch #(
  parameter int unsigned fifo_depth = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,

  output logic [31:0] wbm_adr_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,

  input  logic        dmar_en,
  input  logic [29:0] dmar_addr,
  input  logic [15:0] dmar_remaining,
  output logic        dmar_next,

  input  logic        down_en,
  input  logic        down_next_frame,
  output logic        down_pcmleft_valid,
  output logic [19:0] down_pcmleft,
  output logic        down_pcmright_valid,
  output logic [19:0] down_pcmright,

  output logic [15:0] underrun_count
);

  localparam int unsigned AW = $clog2(fifo_depth);

  typedef enum logic [1:0] {IDLE, READ, TURN} state_t;

  state_t        state;
  logic [31:0]   mem [fifo_depth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic [31:0]   head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          flush;
  logic          push;
  logic          service;
  logic          pop;

  always_comb begin
    fifo_full  = (level == (AW+1)'(fifo_depth));
    fifo_empty = (level == '0);
    flush      = (state == IDLE) && !dmar_en;
    push       = (state == READ) && wbm_ack_i;
    service    = down_en && down_next_frame;
    // A flushing FIFO is treated as empty so nothing stale reaches the frame builder.
    pop        = service && !fifo_empty && !flush;
    head       = mem[rd_ptr];
  end

  assign wbm_stb_o = wbm_cyc_o;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst && push)
      mem[wr_ptr] <= wbm_dat_i;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state               <= IDLE;
      wbm_adr_o           <= '0;
      wbm_cyc_o           <= 1'b0;
      dmar_next           <= 1'b0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      level               <= '0;
      down_pcmleft_valid  <= 1'b0;
      down_pcmleft        <= '0;
      down_pcmright_valid <= 1'b0;
      down_pcmright       <= '0;
    end else begin
      dmar_next <= 1'b0;
      case (state)
        IDLE: begin
          if (dmar_en && (dmar_remaining != '0) && !fifo_full) begin
            wbm_adr_o <= {dmar_addr, 2'b00};
            wbm_cyc_o <= 1'b1;
            state     <= READ;
          end
        end
        READ: begin
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            dmar_next <= 1'b1;
            state     <= TURN;
          end
        end
        TURN:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      level <= level + (AW+1)'(1);
        else if (pop && !push) level <= level - (AW+1)'(1);
      end

      if (service) begin
        if (pop) begin
          down_pcmleft_valid  <= 1'b1;
          down_pcmleft        <= {head[31:16], 4'h0};
          down_pcmright_valid <= 1'b1;
          down_pcmright       <= {head[15:0], 4'h0};
        end else begin
          down_pcmleft_valid  <= 1'b0;
          down_pcmleft        <= '0;
          down_pcmright_valid <= 1'b0;
          down_pcmright       <= '0;
        end
      end
    end
  end

`ifdef AC97_DMAR_UNDERRUN_CNT_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      underrun_count <= '0;
    else if (service && fifo_empty && dmar_en && (underrun_count != '1))
      underrun_count <= underrun_count + 16'd1;
  end
`else
  assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_ac97_dmar_fetch.sv
// Bench for ac97_dmar_fetch: table vectors, hand sequences and a randomized queue-model run.
module tb_ac97_dmar_fetch;

  localparam int unsigned DEPTH = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [31:0] wbm_adr_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic        dmar_en;
  logic [29:0] dmar_addr;
  logic [15:0] dmar_remaining;
  logic        dmar_next;
  logic        down_en;
  logic        down_next_frame;
  logic        down_pcmleft_valid;
  logic [19:0] down_pcmleft;
  logic        down_pcmright_valid;
  logic [19:0] down_pcmright;
  logic [15:0] underrun_count;

  always #5 sys_clk = ~sys_clk;

  ac97_dmar_fetch #(.fifo_depth(DEPTH)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .wbm_adr_o(wbm_adr_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
    .dmar_en(dmar_en), .dmar_addr(dmar_addr), .dmar_remaining(dmar_remaining),
    .dmar_next(dmar_next),
    .down_en(down_en), .down_next_frame(down_next_frame),
    .down_pcmleft_valid(down_pcmleft_valid), .down_pcmleft(down_pcmleft),
    .down_pcmright_valid(down_pcmright_valid), .down_pcmright(down_pcmright),
    .underrun_count(underrun_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: words in flight to the frame builder, plus held frame outputs.
  logic [31:0] mq[$];
  int unsigned uc = 0;
  bit          m_turn = 1'b0;
  logic        exp_lv = 1'b0, exp_rv = 1'b0;
  logic [19:0] exp_l = '0, exp_r = '0;
  int          reads = 0, pulses = 0, cyc_no = 0;
  logic [31:0] rd_adr[$];
  int          rd_cyc[$];

  bit          slave_on = 1'b1;
  bit          rand_wait = 1'b0;
  int          ack_wait = 0;
  int          wcnt = 0;
  logic [31:0] slave_q[$];

  typedef struct {
    logic [31:0] word;
    logic [19:0] left;
    logic [19:0] right;
  } vec_t;
  vec_t tv[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC3A50F1E;
  endfunction

  function automatic logic [15:0] exp_uc();
`ifdef AC97_DMAR_UNDERRUN_CNT_EN
    return (uc > 32'hFFFF) ? 16'hFFFF : 16'(uc);
`else
    return 16'h0;
`endif
  endfunction

  task automatic step();
    bit          s_rst, s_ack, s_cyc, s_frame, s_en, s_turn, qualify;
    logic [31:0] s_dat, s_adr_o, w;
    logic [29:0] s_addr;
    logic [15:0] s_rem;
    s_rst = sys_rst; s_ack = wbm_ack_i; s_cyc = wbm_cyc_o;
    s_frame = down_en && down_next_frame; s_en = dmar_en;
    s_dat = wbm_dat_i; s_adr_o = wbm_adr_o; s_addr = dmar_addr; s_rem = dmar_remaining;
    s_turn = m_turn;
    @(posedge sys_clk);
    @(negedge sys_clk);
    cyc_no++;
    if (s_rst) begin
      mq.delete(); uc = 0; m_turn = 1'b0;
      exp_lv = 1'b0; exp_rv = 1'b0; exp_l = '0; exp_r = '0;
      chk("rst_cyc", 32'(wbm_cyc_o), 0);
    end else begin
      if (!s_en && !s_cyc && !s_turn) mq.delete();
      if (!s_cyc && !s_turn) begin
        qualify = s_en && (s_rem != 16'd0) && (mq.size() < DEPTH);
        chk("req_start", 32'(wbm_cyc_o), 32'(qualify));
        if (qualify) chk("req_adr", wbm_adr_o, {s_addr, 2'b00});
      end
      if (s_cyc) chk("cyc_hold", 32'(wbm_cyc_o), 32'(!s_ack));
      if (s_frame) begin
        if (mq.size() > 0) begin
          w = mq.pop_front();
          exp_lv = 1'b1; exp_rv = 1'b1;
          exp_l = {w[31:16], 4'h0}; exp_r = {w[15:0], 4'h0};
        end else begin
          exp_lv = 1'b0; exp_rv = 1'b0; exp_l = '0; exp_r = '0;
          if (s_en) uc++;
        end
      end
      m_turn = s_ack && s_cyc;
      if (m_turn) begin
        mq.push_back(s_dat);
        reads++;
        rd_adr.push_back(s_adr_o);
        rd_cyc.push_back(cyc_no);
      end
    end
    chk("dmar_next", 32'(dmar_next), 32'(m_turn));
    chk("stb_eq_cyc", 32'(wbm_stb_o), 32'(wbm_cyc_o));
    chk("left_valid", 32'(down_pcmleft_valid), 32'(exp_lv));
    chk("left", 32'(down_pcmleft), 32'(exp_l));
    chk("right_valid", 32'(down_pcmright_valid), 32'(exp_rv));
    chk("right", 32'(down_pcmright), 32'(exp_r));
    chk("underrun", 32'(underrun_count), 32'(exp_uc()));
    if (dmar_next) begin
      pulses++;
      dmar_addr = dmar_addr + 30'd1;
      dmar_remaining = dmar_remaining - 16'd1;
    end
    if (slave_on) begin
      if (wbm_cyc_o && !sys_rst) begin
        if (wcnt >= ack_wait) begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = (slave_q.size() > 0) ? slave_q.pop_front() : data_of(wbm_adr_o);
          wcnt = 0;
          if (rand_wait) ack_wait = $urandom_range(0, 3);
        end else begin
          wbm_ack_i = 1'b0;
          wcnt++;
        end
      end else begin
        wbm_ack_i = 1'b0;
        wcnt = 0;
      end
    end
  endtask

  task automatic frame();
    down_en = 1'b1;
    down_next_frame = 1'b1;
    step();
    down_next_frame = 1'b0;
  endtask

  task automatic wait_cyc(input int bound, input string name);
    for (int i = 0; i < bound && !wbm_cyc_o; i++) step();
    chk(name, 32'(wbm_cyc_o), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, p0;
    bit got;
    tv[0] = '{32'h12345678, 20'h12340, 20'h56780};
    tv[1] = '{32'h9ABC0001, 20'h9ABC0, 20'h00010};
    tv[2] = '{32'hFFFF0000, 20'hFFFF0, 20'h00000};
    tv[3] = '{32'h0000FFFF, 20'h00000, 20'hFFFF0};

    sys_rst = 1'b1; wbm_ack_i = 1'b0; wbm_dat_i = '0;
    dmar_en = 1'b0; dmar_addr = '0; dmar_remaining = '0;
    down_en = 1'b0; down_next_frame = 1'b0;
    step(); step();
    chk("rst_adr", wbm_adr_o, 0);
    chk("rst_next", 32'(dmar_next), 0);
    chk("rst_uc", 32'(underrun_count), 0);
    sys_rst = 1'b0;

    // Table-driven fetch and playback
    foreach (tv[i]) slave_q.push_back(tv[i].word);
    rd_adr.delete(); rd_cyc.delete();
    r0 = reads; p0 = pulses;
    dmar_addr = 30'h100; dmar_remaining = 16'd4; dmar_en = 1'b1;
    for (int i = 0; i < 40 && !(dmar_remaining == 16'd0 && !wbm_cyc_o && !dmar_next); i++) step();
    chk("tbl_reads", reads - r0, 4);
    chk("tbl_pulses", pulses - p0, 4);
    for (int i = 0; i < 4; i++) begin
      if (rd_adr.size() > i) chk("tbl_adr", rd_adr[i], 32'h400 + 32'(4 * i));
      else chk("tbl_adr_missing", rd_adr.size(), i + 1);
      if (i > 0 && rd_cyc.size() > i) chk("tbl_word_gap", rd_cyc[i] - rd_cyc[i-1], 3);
    end
    foreach (tv[i]) begin
      frame();
      chk("tbl_lv", 32'(down_pcmleft_valid), 1);
      chk("tbl_left", 32'(down_pcmleft), 32'(tv[i].left));
      chk("tbl_rv", 32'(down_pcmright_valid), 1);
      chk("tbl_right", 32'(down_pcmright), 32'(tv[i].right));
      step();
    end
    frame();
    chk("tbl_end_lv", 32'(down_pcmleft_valid), 0);
    chk("tbl_end_left", 32'(down_pcmleft), 0);

    // FIFO full stops fetching
    dmar_en = 1'b0; step(); step();
    dmar_en = 1'b1; dmar_addr = 30'h200; dmar_remaining = 16'd10;
    r0 = reads;
    repeat (30) step();
    chk("full_reads", reads - r0, 4);
    chk("full_cyc_idle", 32'(wbm_cyc_o), 0);
    frame();
    repeat (10) step();
    chk("full_one_more", reads - r0, 5);

    // Underrun with nothing to fetch
    dmar_en = 1'b0; step(); step();
    dmar_en = 1'b1; dmar_remaining = 16'd0;
    begin
      logic [15:0] ucb;
      ucb = exp_uc();
      repeat (3) begin
        frame();
        chk("urun_lv", 32'(down_pcmleft_valid), 0);
        chk("urun_rv", 32'(down_pcmright_valid), 0);
        chk("urun_data", {12'h0, down_pcmleft} | {12'h0, down_pcmright}, 0);
        step();
      end
`ifdef AC97_DMAR_UNDERRUN_CNT_EN
      chk("urun_count", 32'(underrun_count), 32'(ucb) + 3);
`else
      chk("urun_count", 32'(underrun_count) | 32'(ucb), 0);
`endif
    end

    // Disable while a read is in flight
    dmar_addr = 30'h2A0; dmar_remaining = 16'd1; ack_wait = 5;
    p0 = pulses;
    wait_cyc(10, "dis_cyc_wait");
    dmar_en = 1'b0;
    repeat (12) step();
    chk("dis_pulses", pulses - p0, 1);
    frame();
    chk("dis_frame_lv", 32'(down_pcmleft_valid), 0);
    ack_wait = 0;

    // Push and pop on the same edge
    dmar_en = 1'b1; dmar_addr = 30'h300; dmar_remaining = 16'd1;
    slave_q.push_back(32'hAAAA5555);
    slave_q.push_back(32'h1234ABCD);
    repeat (6) step();
    ack_wait = 2; dmar_remaining = 16'd1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = wbm_ack_i;
    end
    chk("pp_ack_wait", 32'(got), 1);
    frame();
    chk("pp_old_left", 32'(down_pcmleft), 32'h0AAAA0);
    chk("pp_old_right", 32'(down_pcmright), 32'h055550);
    step();
    frame();
    chk("pp_new_left", 32'(down_pcmleft), 32'h012340);
    chk("pp_new_right", 32'(down_pcmright), 32'h0ABCD0);
    frame();
    chk("pp_then_empty", 32'(down_pcmleft_valid), 0);
    ack_wait = 0;

    // Reset while a read is pending
    dmar_remaining = 16'd1;
    repeat (5) step();
    slave_on = 1'b0; wbm_ack_i = 1'b0;
    dmar_remaining = 16'd1;
    wait_cyc(10, "rst_cyc_wait");
    sys_rst = 1'b1; dmar_en = 1'b0;
    step();
    sys_rst = 1'b0;
    chk("rst_mid_cyc", 32'(wbm_cyc_o), 0);
    p0 = pulses;
    wbm_ack_i = 1'b1; wbm_dat_i = 32'hDEADBEEF;
    step();
    wbm_ack_i = 1'b0;
    step();
    chk("rst_late_ack", pulses - p0, 0);
    dmar_en = 1'b1; dmar_remaining = 16'd0;
    frame();
    chk("rst_fifo_empty", 32'(down_pcmleft_valid), 0);
    slave_on = 1'b1;

    // Randomized traffic against the queue model
    dmar_addr = 30'($urandom());
    dmar_remaining = 16'd40;
    rand_wait = 1'b1; ack_wait = $urandom_range(0, 3);
    for (int i = 0; i < 600; i++) begin
      down_en = ($urandom_range(0, 9) != 0);
      down_next_frame = ($urandom_range(0, 3) == 0);
      step();
    end
    down_next_frame = 1'b0; rand_wait = 1'b0;
    repeat (8) step();
    chk("rand_drained_rem", 32'(dmar_remaining), 0);
    chk("pulse_total", pulses, reads);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
